// File: rtl/dcache_port_arbiter_pkg.sv
// Shared definitions for the two-port DCache request arbiter: state
// encoding, op and size codes, bus widths and the latched request record.
package dcache_port_arbiter_pkg;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int BYTES_W = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Request op encoding
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Size codes (bytes-1)
  localparam logic [BYTES_W-1:0] SZ_B = 4'd0;
  localparam logic [BYTES_W-1:0] SZ_H = 4'd1;
  localparam logic [BYTES_W-1:0] SZ_W = 4'd3;
  localparam logic [BYTES_W-1:0] SZ_D = 4'd7;

  // One-hot grant values
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  // Fields carried from a requester to the DCache port
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               op;
    logic [BYTES_W-1:0] bytes;
    logic [DATA_W-1:0]  wdata;
  } dc_req_t;

  // Bundle one requester's fields into a request record
  function automatic dc_req_t pack_req(input logic [ADDR_W-1:0]  addr,
                                       input logic               op,
                                       input logic [BYTES_W-1:0] bytes,
                                       input logic [DATA_W-1:0]  wdata);
    dc_req_t r;
    r.addr  = addr;
    r.op    = op;
    r.bytes = bytes;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_rr_arbiter2.sv
// Two-way winner select. Produces a one-hot grant from {req1,req0}.
// PRIO_MODE=0: round-robin, on a tie the port not granted last wins.
// PRIO_MODE=1: fixed priority, m0 always wins a tie.
// A single requester always wins in either mode.
module rr_arbiter2
  import dcache_port_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant, // 1 = m1 was granted last
  output logic [1:0] grant
);

  // Pick the winner; no request gives an all-zero grant
  always_comb begin
    grant = GNT_NONE;
    case (req)
      2'b01: grant = GNT_M0;
      2'b10: grant = GNT_M1;
      2'b11: begin
        if (PRIO_MODE != 0) begin
          grant = GNT_M0;
        end else begin
          grant = last_grant ? GNT_M0 : GNT_M1;
        end
      end
      default: grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one DCache req/ack port between m0 (memory stage) and m1
// (secondary client). The winning request is registered and held until
// the DCache acks, then a single registered ack pulse with latched rdata
// is returned to the winner. All outputs come straight from flops.
//
// Handshake: a requester raises req with stable fields and holds them
// until its one-cycle ack; it drops or renews req on the edge that ends
// the ack cycle. Toward the DCache, o_dcache_req and fields stay stable
// until the one-cycle i_dcache_ack; an ack outside BUSY is ignored.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_m0_req,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic                i_m0_op,
  input  logic [BYTES_W-1:0]  i_m0_bytes,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  output logic                o_m0_ack,
  output logic [DATA_W-1:0]   o_m0_rdata,
  input  logic                i_m1_req,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic                i_m1_op,
  input  logic [BYTES_W-1:0]  i_m1_bytes,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  output logic                o_m1_ack,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_dcache_req,
  output logic [ADDR_W-1:0]   o_dcache_addr,
  output logic                o_dcache_op,
  output logic [BYTES_W-1:0]  o_dcache_bytes,
  output logic [DATA_W-1:0]   o_dcache_wdata,
  input  logic                i_dcache_ack,
  input  logic [DATA_W-1:0]   i_dcache_rdata,
  output logic [1:0]          o_grant,
  output logic                o_busy
);

  state_t     state;
  state_t     state_next;
  logic       last_grant;   // 1 = m1 owned the previous transaction
  logic [1:0] arb_grant;
  logic       load_req;     // IDLE with a request: capture the winner
  logic       complete;     // BUSY with DCache ack: return data
  logic       finish;       // RESP: close out the transaction
  dc_req_t    m0_fields;
  dc_req_t    m1_fields;
  dc_req_t    win_req;

  rr_arbiter2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .req        ({i_m1_req, i_m0_req}),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  assign m0_fields = pack_req(i_m0_addr, i_m0_op, i_m0_bytes, i_m0_wdata);
  assign m1_fields = pack_req(i_m1_addr, i_m1_op, i_m1_bytes, i_m1_wdata);

  // Steer the winning requester's fields toward the capture registers
  always_comb begin
    win_req = m0_fields;
    if (arb_grant[1]) begin
      win_req = m1_fields;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-state action strobes
  always_comb begin
    state_next = state;
    load_req   = 1'b0;
    complete   = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_m0_req || i_m1_req) begin
          load_req   = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_dcache_ack) begin
          complete   = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        finish     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs: capture, completion and close-out of a transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      o_dcache_req   <= 1'b0;
      o_dcache_addr  <= '0;
      o_dcache_op    <= OP_READ;
      o_dcache_bytes <= SZ_B;
      o_dcache_wdata <= '0;
      o_m0_ack       <= 1'b0;
      o_m1_ack       <= 1'b0;
      o_m0_rdata     <= '0;
      o_m1_rdata     <= '0;
      o_grant        <= GNT_NONE;
      o_busy         <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      if (load_req) begin
        o_dcache_req   <= 1'b1;
        o_dcache_addr  <= win_req.addr;
        o_dcache_op    <= win_req.op;
        o_dcache_bytes <= win_req.bytes;
        o_dcache_wdata <= win_req.wdata;
        o_grant        <= arb_grant;
        last_grant     <= arb_grant[1];
        o_busy         <= 1'b1;
      end
      if (complete) begin
        o_dcache_req <= 1'b0;
        // rdata is latched for writes too; it simply mirrors the DCache bus
        if (o_grant[0]) begin
          o_m0_ack   <= 1'b1;
          o_m0_rdata <= i_dcache_rdata;
        end
        if (o_grant[1]) begin
          o_m1_ack   <= 1'b1;
          o_m1_rdata <= i_dcache_rdata;
        end
      end
      if (finish) begin
        o_m0_ack <= 1'b0;
        o_m1_ack <= 1'b0;
        o_grant  <= GNT_NONE;
        o_busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter. Two instances share all inputs:
// dut_a is round-robin, dut_b is fixed priority. A request scoreboard holds
// the expected grant and latched fields; entries are popped when dut_a
// presents o_dcache_req.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int EXP_W = 2 + 1 + BYTES_W + ADDR_W + DATA_W;

  logic         clk;
  logic         rst;
  logic         m0_req, m1_req, m0_op, m1_op;
  logic [63:0]  m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]   m0_bytes, m1_bytes;
  logic         dc_ack;
  logic [63:0]  dc_rdata;

  logic         a_m0_ack, a_m1_ack, a_dc_req, a_dc_op, a_busy;
  logic [63:0]  a_m0_rdata, a_m1_rdata, a_dc_addr, a_dc_wdata;
  logic [3:0]   a_dc_bytes;
  logic [1:0]   a_grant;
  logic         b_m0_ack, b_m1_ack, b_dc_req, b_dc_op, b_busy;
  logic [63:0]  b_m0_rdata, b_m1_rdata, b_dc_addr, b_dc_wdata;
  logic [3:0]   b_dc_bytes;
  logic [1:0]   b_grant;

  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       exp_b_q[$];

  int checks = 0;
  int errors = 0;
  int a_m0_cnt = 0, a_m1_cnt = 0, b_m0_cnt = 0, b_m1_cnt = 0;

  dcache_port_arbiter #(.PRIO_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_op(m0_op),
    .i_m0_bytes(m0_bytes), .i_m0_wdata(m0_wdata),
    .o_m0_ack(a_m0_ack), .o_m0_rdata(a_m0_rdata),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_op(m1_op),
    .i_m1_bytes(m1_bytes), .i_m1_wdata(m1_wdata),
    .o_m1_ack(a_m1_ack), .o_m1_rdata(a_m1_rdata),
    .o_dcache_req(a_dc_req), .o_dcache_addr(a_dc_addr), .o_dcache_op(a_dc_op),
    .o_dcache_bytes(a_dc_bytes), .o_dcache_wdata(a_dc_wdata),
    .i_dcache_ack(dc_ack), .i_dcache_rdata(dc_rdata),
    .o_grant(a_grant), .o_busy(a_busy)
  );

  dcache_port_arbiter #(.PRIO_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .i_m0_req(m0_req), .i_m0_addr(m0_addr), .i_m0_op(m0_op),
    .i_m0_bytes(m0_bytes), .i_m0_wdata(m0_wdata),
    .o_m0_ack(b_m0_ack), .o_m0_rdata(b_m0_rdata),
    .i_m1_req(m1_req), .i_m1_addr(m1_addr), .i_m1_op(m1_op),
    .i_m1_bytes(m1_bytes), .i_m1_wdata(m1_wdata),
    .o_m1_ack(b_m1_ack), .o_m1_rdata(b_m1_rdata),
    .o_dcache_req(b_dc_req), .o_dcache_addr(b_dc_addr), .o_dcache_op(b_dc_op),
    .o_dcache_bytes(b_dc_bytes), .o_dcache_wdata(b_dc_wdata),
    .i_dcache_ack(dc_ack), .i_dcache_rdata(dc_rdata),
    .o_grant(b_grant), .o_busy(b_busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ack pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (a_m0_ack) a_m0_cnt++;
      if (a_m1_ack) a_m1_cnt++;
      if (b_m0_ack) b_m0_cnt++;
      if (b_m1_ack) b_m1_cnt++;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk_exp(input logic [1:0] g, input logic op,
                                              input logic [3:0] bytes, input logic [63:0] addr,
                                              input logic [63:0] wdata);
    return {g, op, bytes, addr, wdata};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_a_grant"}, 64'(a_grant), 64'(GNT_NONE));
    chk({tag, "_a_busy"}, 64'(a_busy), 64'd0);
    chk({tag, "_a_dc_req"}, 64'(a_dc_req), 64'd0);
    chk({tag, "_a_m0_ack"}, 64'(a_m0_ack), 64'd0);
    chk({tag, "_a_m1_ack"}, 64'(a_m1_ack), 64'd0);
    chk({tag, "_b_grant"}, 64'(b_grant), 64'(GNT_NONE));
    chk({tag, "_b_busy"}, 64'(b_busy), 64'd0);
  endtask

  // DCache model: wait for the request, check it, hold off, then ack once
  task automatic serve(input int wait_cyc, input logic [63:0] rdata);
    logic [EXP_W-1:0] e;
    logic [1:0]       eg;
    logic [1:0]       bg;
    logic             have_b;
    int               n;
    n = 0;
    while (a_dc_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", 64'(a_dc_req), 64'd1);
    chk("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    eg = e[EXP_W-1 -: 2];
    chk("a_grant", 64'(a_grant), 64'(eg));
    chk("a_busy", 64'(a_busy), 64'd1);
    chk("a_dc_op", 64'(a_dc_op), 64'(e[132]));
    chk("a_dc_bytes", 64'(a_dc_bytes), 64'(e[131:128]));
    chk("a_dc_addr", a_dc_addr, e[127:64]);
    chk("a_dc_wdata", a_dc_wdata, e[63:0]);
    have_b = (exp_b_q.size() > 0);
    bg = GNT_NONE;
    if (have_b) begin
      bg = exp_b_q.pop_front();
      chk("b_grant", 64'(b_grant), 64'(bg));
    end
    repeat (wait_cyc) begin
      step();
      chk("addr_hold", a_dc_addr, e[127:64]);
      chk("req_hold", 64'(a_dc_req), 64'd1);
      chk("no_early_ack", 64'({a_m1_ack, a_m0_ack}), 64'd0);
    end
    dc_ack   = 1'b1;
    dc_rdata = rdata;
    step();
    dc_ack   = 1'b0;
    dc_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
    chk("a_m0_ack", 64'(a_m0_ack), 64'(eg[0]));
    chk("a_m1_ack", 64'(a_m1_ack), 64'(eg[1]));
    chk("a_dc_req_drop", 64'(a_dc_req), 64'd0);
    chk("a_busy_resp", 64'(a_busy), 64'd1);
    if (eg[0]) chk("a_m0_rdata", a_m0_rdata, rdata);
    else       chk("a_m1_rdata", a_m1_rdata, rdata);
    if (have_b) begin
      chk("b_m0_ack", 64'(b_m0_ack), 64'(bg[0]));
      chk("b_m1_ack", 64'(b_m1_ack), 64'(bg[1]));
    end
  endtask

  initial begin
    int c0, c1, d0, d1;
    rst = 1'b1;
    m0_req = 1'b0; m0_addr = '0; m0_op = OP_READ; m0_bytes = SZ_B; m0_wdata = '0;
    m1_req = 1'b0; m1_addr = '0; m1_op = OP_READ; m1_bytes = SZ_B; m1_wdata = '0;
    dc_ack = 1'b0; dc_rdata = '0;
    step();
    step();

    // Reset state
    chk_idle("reset");
    chk("reset_a_m0_rdata", a_m0_rdata, 64'd0);
    chk("reset_a_dc_addr", a_dc_addr, 64'd0);
    rst = 1'b0;

    // Single read from m0, DCache acks two cycles after the request
    c0 = a_m0_cnt; c1 = a_m1_cnt;
    m0_req = 1'b1; m0_addr = 64'h8000_1000; m0_op = OP_READ; m0_bytes = SZ_D; m0_wdata = '0;
    exp_q.push_back(mk_exp(GNT_M0, OP_READ, SZ_D, 64'h8000_1000, 64'd0));
    exp_b_q.push_back(GNT_M0);
    serve(2, 64'h1122_3344_5566_7788);
    m0_req = 1'b0;
    step();
    chk_idle("t1_done");
    chk("t1_m0_rdata_hold", a_m0_rdata, 64'h1122_3344_5566_7788);
    chk("t1_m0_ack_count", 64'(a_m0_cnt - c0), 64'd1);
    chk("t1_m1_ack_count", 64'(a_m1_cnt - c1), 64'd0);

    // Spurious DCache ack while idle
    c0 = a_m0_cnt; c1 = a_m1_cnt;
    dc_ack = 1'b1; dc_rdata = 64'hDEAD;
    step();
    dc_ack = 1'b0;
    step();
    chk_idle("spur");
    chk("spur_m0_rdata", a_m0_rdata, 64'h1122_3344_5566_7788);
    chk("spur_m1_rdata", a_m1_rdata, 64'd0);
    chk("spur_ack_count", 64'((a_m0_cnt - c0) + (a_m1_cnt - c1)), 64'd0);

    // Long DCache hold-off while m0 changes its address mid-transaction
    c0 = a_m0_cnt;
    m0_req = 1'b1; m0_addr = 64'h8000_0080; m0_op = OP_WRITE; m0_bytes = SZ_W;
    m0_wdata = 64'h0000_0000_CAFE_F00D;
    exp_q.push_back(mk_exp(GNT_M0, OP_WRITE, SZ_W, 64'h8000_0080, 64'h0000_0000_CAFE_F00D));
    exp_b_q.push_back(GNT_M0);
    step();
    m0_addr = 64'h8000_0100;
    serve(10, 64'h5A5A_0000_1234_5678);
    m0_req = 1'b0;
    step();
    chk_idle("hold_done");
    chk("hold_m0_ack_count", 64'(a_m0_cnt - c0), 64'd1);

    // m1 drops req while BUSY; transaction still completes
    c1 = a_m1_cnt;
    m1_req = 1'b1; m1_addr = 64'h8000_0060; m1_op = OP_READ; m1_bytes = SZ_H; m1_wdata = '0;
    exp_q.push_back(mk_exp(GNT_M1, OP_READ, SZ_H, 64'h8000_0060, 64'd0));
    exp_b_q.push_back(GNT_M1);
    step();
    m1_req = 1'b0;
    serve(1, 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk_idle("drop_done");
    chk("drop_m1_ack_count", 64'(a_m1_cnt - c1), 64'd1);

    // Reset while m1 owns a BUSY transaction
    c1 = a_m1_cnt;
    m1_req = 1'b1; m1_addr = 64'h8000_0040; m1_op = OP_READ; m1_bytes = SZ_D;
    step();
    chk("rst_pre_req", 64'(a_dc_req), 64'd1);
    chk("rst_pre_grant", 64'(a_grant), 64'(GNT_M1));
    chk("rst_pre_addr", a_dc_addr, 64'h8000_0040);
    rst = 1'b1;
    step();
    chk_idle("rst_mid");
    chk("rst_mid_addr", a_dc_addr, 64'd0);
    chk("rst_mid_m1_rdata", a_m1_rdata, 64'd0);
    rst = 1'b0;
    exp_q.push_back(mk_exp(GNT_M1, OP_READ, SZ_D, 64'h8000_0040, 64'd0));
    exp_b_q.push_back(GNT_M1);
    serve(0, 64'h0123_4567_89AB_CDEF);
    m1_req = 1'b0;
    step();
    chk_idle("rst_regrant_done");
    chk("rst_m1_ack_count", 64'(a_m1_cnt - c1), 64'd1);

    // Both ports continuously requesting, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    c0 = a_m0_cnt; c1 = a_m1_cnt; d0 = b_m0_cnt; d1 = b_m1_cnt;
    m0_req = 1'b1; m0_addr = 64'h8000_0010; m0_op = OP_WRITE; m0_bytes = SZ_B; m0_wdata = 64'hAB;
    m1_req = 1'b1; m1_addr = 64'h8000_0020; m1_op = OP_READ;  m1_bytes = SZ_D; m1_wdata = 64'h55;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back(mk_exp(GNT_M0, OP_WRITE, SZ_B, 64'h8000_0010, 64'hAB));
      else            exp_q.push_back(mk_exp(GNT_M1, OP_READ, SZ_D, 64'h8000_0020, 64'h55));
      exp_b_q.push_back(GNT_M0);
    end
    for (int i = 0; i < 4; i++) begin
      serve(i % 2, 64'h1000 + 64'(i));
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    chk_idle("both_done");
    chk("rr_m0_count", 64'(a_m0_cnt - c0), 64'd2);
    chk("rr_m1_count", 64'(a_m1_cnt - c1), 64'd2);
    chk("prio_m0_count", 64'(b_m0_cnt - d0), 64'd4);
    chk("prio_m1_count", 64'(b_m1_cnt - d1), 64'd0);

    // Back-to-back from m0 with m1 idle: re-granted one IDLE cycle after RESP
    m0_req = 1'b1; m0_addr = 64'h8000_0200; m0_op = OP_READ; m0_bytes = SZ_D; m0_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk_exp(GNT_M0, OP_READ, SZ_D, 64'h8000_0200, 64'd0));
      exp_b_q.push_back(GNT_M0);
    end
    serve(0, 64'h7777_0000_0000_0001);
    step();
    chk("b2b_idle_gap", 64'(a_dc_req), 64'd0);
    step();
    chk("b2b_regrant", 64'(a_dc_req), 64'd1);
    serve(0, 64'h7777_0000_0000_0002);
    m0_req = 1'b0;
    step();
    chk_idle("b2b_done");

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
